// File: rtl/round_sequencer_pkg.sv
// Shared types and helpers for the Genius round sequencer: state encoding,
// symbol/level sizing, symbol-to-button mapping and the sequence LFSR.
package genius_pkg;

    localparam int SYM_W     = 2;
    localparam int LVL_W     = 4;
    localparam int BTN_W     = 3;
    localparam int MAX_LEVEL = 15;
    localparam int SEQ_LEN   = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FILL     = 4'd1,
        ST_SHOW_ON  = 4'd2,
        ST_SHOW_GAP = 4'd3,
        ST_WAIT_IN  = 4'd4,
        ST_WAIT_REL = 4'd5,
        ST_NEXT_LVL = 4'd6,
        ST_WIN      = 4'd7,
        ST_LOSE     = 4'd8
    } state_e;

    // Button pattern a correct press must match exactly.
    function automatic logic [BTN_W-1:0] sym_onehot(input logic [SYM_W-1:0] s);
        logic [BTN_W-1:0] oh;
        case (s)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Fold the unused code 3 back onto 0/1 so every symbol stays in range.
    function automatic logic [SYM_W-1:0] lfsr_sym(input logic [7:0] v);
        logic [SYM_W-1:0] s;
        if (v[1:0] == 2'd3) begin
            s = {1'b0, v[2]};
        end else begin
            s = v[1:0];
        end
        return s;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake bundle between the game FSM / display datapath and the round sequencer.
interface round_sequencer_if;
    import genius_pkg::*;

    logic                start;
    logic [BTN_W-1:0]    btn;
    logic [SYM_W-1:0]    sym;
    logic                sym_valid;
    logic [LVL_W-1:0]    level;
    logic [LVL_W-1:0]    step;
    logic                busy;
    logic                win;
    logic                lose;

    modport master (
        output start, btn,
        input  sym, sym_valid, level, step, busy, win, lose
    );

    modport slave (
        input  start, btn,
        output sym, sym_valid, level, step, busy, win, lose
    );

endinterface

// File: rtl/round_sequencer_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV cycles; clear restarts
// the count so that the current cycle is count zero.
module tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] cnt_r;
    logic [PRE_W-1:0] cnt_eff_s;

    // Effective count for this cycle and the tick decode.
    always_comb begin
        cnt_eff_s = clear ? {PRE_W{1'b0}} : cnt_r;
        tick      = (cnt_eff_s == PRE_W'(TICK_DIV - 1));
    end

    // Prescaler register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {PRE_W{1'b0}};
        end else if (tick) begin
            cnt_r <= {PRE_W{1'b0}};
        end else begin
            cnt_r <= cnt_eff_s + PRE_W'(1);
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Genius round controller: fills a 16-symbol sequence from an LFSR, plays back
// level+1 symbols with fixed timing, then checks the player's presses in order.
module round_sequencer
    import genius_pkg::*;
#(
    parameter int         TICK_DIV      = 25_000_000,
    parameter int         ON_TICKS      = 2,
    parameter int         GAP_TICKS     = 1,
    parameter int         TIMEOUT_TICKS = 10,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    round_sequencer_if.slave   bus
);

    localparam int TMAX_A = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TMAX   = (TMAX_A > TIMEOUT_TICKS) ? TMAX_A : TIMEOUT_TICKS;
    localparam int TCNT_W = $clog2(TMAX + 1);

    state_e              state_r;
    state_e              prev_state_r;
    logic [7:0]          lfsr_r;
    logic [SYM_W-1:0]    seq_r [SEQ_LEN];
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    step_r;
    logic [TCNT_W-1:0]   tick_cnt_r;
    logic [SYM_W-1:0]    sym_r;
    logic                sym_valid_r;
    logic                busy_r;
    logic                win_r;
    logic                lose_r;

    logic                clear_s;
    logic                tick_s;
    logic [TCNT_W-1:0]   tcnt_eff_s;
    logic                on_done_s;
    logic                gap_done_s;
    logic                timeout_s;
    logic                press_ok_s;

    // A state change restarts both the prescaler and the tick count, so every
    // timed state lasts a whole number of ticks measured from its entry.
    always_comb begin
        clear_s    = (state_r != prev_state_r);
        tcnt_eff_s = clear_s ? {TCNT_W{1'b0}} : tick_cnt_r;
        on_done_s  = tick_s && (tcnt_eff_s == TCNT_W'(ON_TICKS - 1));
        gap_done_s = tick_s && (tcnt_eff_s == TCNT_W'(GAP_TICKS - 1));
        timeout_s  = tick_s && (tcnt_eff_s == TCNT_W'(TIMEOUT_TICKS - 1));
        press_ok_s = (bus.btn == sym_onehot(seq_r[step_r]));
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Round FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            prev_state_r <= ST_IDLE;
            lfsr_r       <= LFSR_SEED;
            for (int i = 0; i < SEQ_LEN; i++) begin
                seq_r[i] <= {SYM_W{1'b0}};
            end
            level_r      <= {LVL_W{1'b0}};
            step_r       <= {LVL_W{1'b0}};
            tick_cnt_r   <= {TCNT_W{1'b0}};
            sym_r        <= {SYM_W{1'b0}};
            sym_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            win_r        <= 1'b0;
            lose_r       <= 1'b0;
        end else begin
            prev_state_r <= state_r;
            tick_cnt_r   <= tick_s ? (tcnt_eff_s + TCNT_W'(1)) : tcnt_eff_s;
            win_r        <= 1'b0;
            lose_r       <= 1'b0;
            case (state_r)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (bus.start) begin
                        state_r <= ST_FILL;
                        level_r <= {LVL_W{1'b0}};
                        step_r  <= {LVL_W{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    seq_r[step_r] <= lfsr_sym(lfsr_r);
                    lfsr_r        <= lfsr_next(lfsr_r);
                    if (step_r == LVL_W'(SEQ_LEN - 1)) begin
                        state_r     <= ST_SHOW_ON;
                        step_r      <= {LVL_W{1'b0}};
                        sym_r       <= seq_r[0];
                        sym_valid_r <= 1'b1;
                    end else begin
                        step_r <= step_r + LVL_W'(1);
                    end
                end
                ST_SHOW_ON: begin
                    if (on_done_s) begin
                        sym_r       <= {SYM_W{1'b0}};
                        sym_valid_r <= 1'b0;
                        if (step_r == level_r) begin
                            state_r <= ST_WAIT_IN;
                            step_r  <= {LVL_W{1'b0}};
                        end else begin
                            state_r <= ST_SHOW_GAP;
                        end
                    end
                end
                ST_SHOW_GAP: begin
                    if (gap_done_s) begin
                        state_r     <= ST_SHOW_ON;
                        step_r      <= step_r + LVL_W'(1);
                        sym_r       <= seq_r[step_r + LVL_W'(1)];
                        sym_valid_r <= 1'b1;
                    end
                end
                ST_WAIT_IN: begin
                    // A press seen on the expiry cycle takes priority over the timeout.
                    if (bus.btn != {BTN_W{1'b0}}) begin
                        if (press_ok_s) begin
                            state_r <= ST_WAIT_REL;
                        end else begin
                            state_r <= ST_LOSE;
                            lose_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_LOSE;
                        lose_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT_REL: begin
                    if (bus.btn == {BTN_W{1'b0}}) begin
                        if (step_r == level_r) begin
                            state_r <= ST_NEXT_LVL;
                        end else begin
                            state_r <= ST_WAIT_IN;
                            step_r  <= step_r + LVL_W'(1);
                        end
                    end
                end
                ST_NEXT_LVL: begin
                    if (level_r == LVL_W'(MAX_LEVEL)) begin
                        state_r <= ST_WIN;
                        win_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r     <= ST_SHOW_ON;
                        level_r     <= level_r + LVL_W'(1);
                        step_r      <= {LVL_W{1'b0}};
                        sym_r       <= seq_r[0];
                        sym_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sym_r       <= {SYM_W{1'b0}};
                    sym_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sym       = sym_r;
    assign bus.sym_valid = sym_valid_r;
    assign bus.level     = level_r;
    assign bus.step      = step_r;
    assign bus.busy      = busy_r;
    assign bus.win       = win_r;
    assign bus.lose      = lose_r;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a fast tick (TICK_DIV=4) so one
// shown symbol lasts 8 cycles, a gap 4 cycles and a press timeout 20 cycles.
module tb_round_sequencer;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    round_sequencer_if bus_if ();

    round_sequencer #(
        .TICK_DIV      (4),
        .ON_TICKS      (2),
        .GAP_TICKS     (1),
        .TIMEOUT_TICKS (5),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  m_lfsr;
    logic [1:0]  m_seq [16];
    logic [13:0] outs;

    assign outs = {bus_if.sym, bus_if.sym_valid, bus_if.level, bus_if.step,
                   bus_if.busy, bus_if.win, bus_if.lose};

    task automatic step_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected round sequence from the 8-bit LFSR (taps 8,6,5,4).
    task automatic model_fill();
        for (int i = 0; i < 16; i++) begin
            if (m_lfsr[1:0] == 2'd3) m_seq[i] = {1'b0, m_lfsr[2]};
            else                     m_seq[i] = m_lfsr[1:0];
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

    task automatic start_game();
        bus_if.start = 1'b1;
        step_clk(1);
        bus_if.start = 1'b0;
        model_fill();
    endtask

    // Entered at the first SHOW_ON cycle; leaves at the first WAIT_IN cycle.
    task automatic do_show(input int lvl);
        for (int s = 0; s <= lvl; s++) begin
            vectors++;
            if ({bus_if.sym_valid, bus_if.sym, bus_if.step} !== {1'b1, m_seq[s], 4'(s)}) begin
                $display("FAIL show_sym lvl=%0d s=%0d: got v/sym/step=%b want %b", lvl, s,
                         {bus_if.sym_valid, bus_if.sym, bus_if.step}, {1'b1, m_seq[s], 4'(s)});
                miscompares++;
            end
            step_clk(7);
            vectors++;
            if (bus_if.sym_valid !== 1'b1) begin
                $display("FAIL show_on_len lvl=%0d s=%0d: got sym_valid=%b want 1", lvl, s, bus_if.sym_valid);
                miscompares++;
            end
            step_clk(1);
            vectors++;
            if ({bus_if.sym_valid, bus_if.sym} !== 3'b000) begin
                $display("FAIL show_off lvl=%0d s=%0d: got v/sym=%b want 000", lvl, s,
                         {bus_if.sym_valid, bus_if.sym});
                miscompares++;
            end
            if (s < lvl) begin
                step_clk(3);
                vectors++;
                if (bus_if.sym_valid !== 1'b0) begin
                    $display("FAIL gap_len lvl=%0d s=%0d: got sym_valid=%b want 0", lvl, s, bus_if.sym_valid);
                    miscompares++;
                end
                step_clk(1);
            end
        end
        vectors++;
        if ({bus_if.busy, bus_if.step} !== {1'b1, 4'd0}) begin
            $display("FAIL wait_in_entry lvl=%0d: got busy/step=%b want 10000", lvl, {bus_if.busy, bus_if.step});
            miscompares++;
        end
    endtask

    // Correct press/release for every step; leaves in NEXT_LVL.
    task automatic do_press(input int lvl);
        for (int s = 0; s <= lvl; s++) begin
            bus_if.btn = onehot(m_seq[s]);
            step_clk(1);
            vectors++;
            if ({bus_if.busy, bus_if.lose} !== 2'b10) begin
                $display("FAIL press_ok lvl=%0d s=%0d: got busy/lose=%b want 10", lvl, s, {bus_if.busy, bus_if.lose});
                miscompares++;
            end
            bus_if.btn = 3'b000;
            step_clk(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.btn = 3'b000;
        step_clk(2);
        vectors++;
        if (outs !== 14'd0) begin
            $display("FAIL reset_outs: got %b want 0", outs);
            miscompares++;
        end
        reset = 1'b0;
        m_lfsr = 8'hA5;
        step_clk(3);
        vectors++;
        if (outs !== 14'd0) begin
            $display("FAIL idle_outs: got %b want 0", outs);
            miscompares++;
        end
    endtask

    task automatic test_start();
        start_game();
        vectors++;
        if ({bus_if.busy, bus_if.sym_valid} !== 2'b10) begin
            $display("FAIL start_busy: got busy/v=%b want 10", {bus_if.busy, bus_if.sym_valid});
            miscompares++;
        end
        step_clk(15);
        vectors++;
        if (bus_if.sym_valid !== 1'b0) begin
            $display("FAIL fill_len: got sym_valid=%b at cycle 16 want 0", bus_if.sym_valid);
            miscompares++;
        end
        step_clk(1);
        // Seed A5: lfsr[1:0]=01, so the first symbol is 1.
        vectors++;
        if ({bus_if.sym_valid, bus_if.sym, bus_if.level, bus_if.step} !== {1'b1, 2'd1, 4'd0, 4'd0}) begin
            $display("FAIL first_sym: got v/sym/level/step=%b want 1010000000",
                     {bus_if.sym_valid, bus_if.sym, bus_if.level, bus_if.step});
            miscompares++;
        end
    endtask

    task automatic test_level_up();
        do_show(0);
        do_press(0);
        step_clk(1);
        vectors++;
        if ({bus_if.level, bus_if.sym_valid} !== {4'd1, 1'b1}) begin
            $display("FAIL level_1: got level/v=%b want 00011", {bus_if.level, bus_if.sym_valid});
            miscompares++;
        end
        do_show(1);
        do_press(1);
        step_clk(1);
        vectors++;
        if (bus_if.level !== 4'd2) begin
            $display("FAIL level_2: got level=%0d want 2", bus_if.level);
            miscompares++;
        end
    endtask

    task automatic test_wrong_button();
        logic [1:0] w;
        do_show(2);
        w = (m_seq[0] == 2'd2) ? 2'd0 : m_seq[0] + 2'd1;
        bus_if.btn = onehot(w);
        step_clk(1);
        vectors++;
        if ({bus_if.lose, bus_if.busy, bus_if.level} !== {1'b1, 1'b0, 4'd2}) begin
            $display("FAIL wrong_lose: got lose/busy/level=%b want 100010", {bus_if.lose, bus_if.busy, bus_if.level});
            miscompares++;
        end
        bus_if.btn = 3'b000;
        step_clk(1);
        vectors++;
        if ({bus_if.lose, bus_if.win, bus_if.busy, bus_if.level} !== {3'b000, 4'd2}) begin
            $display("FAIL lose_pulse: got lose/win/busy/level=%b want 0000010",
                     {bus_if.lose, bus_if.win, bus_if.busy, bus_if.level});
            miscompares++;
        end
    endtask

    task automatic test_multi_bit();
        start_game();
        step_clk(16);
        do_show(0);
        bus_if.btn = 3'b011;
        step_clk(1);
        vectors++;
        if ({bus_if.lose, bus_if.busy, bus_if.level} !== {1'b1, 1'b0, 4'd0}) begin
            $display("FAIL multi_bit: got lose/busy/level=%b want 100000", {bus_if.lose, bus_if.busy, bus_if.level});
            miscompares++;
        end
        bus_if.btn = 3'b000;
        step_clk(1);
    endtask

    task automatic test_timeout();
        start_game();
        step_clk(16);
        do_show(0);
        step_clk(19);
        vectors++;
        if ({bus_if.busy, bus_if.lose} !== 2'b10) begin
            $display("FAIL timeout_early: got busy/lose=%b want 10", {bus_if.busy, bus_if.lose});
            miscompares++;
        end
        step_clk(1);
        vectors++;
        if ({bus_if.busy, bus_if.lose} !== 2'b01) begin
            $display("FAIL timeout_lose: got busy/lose=%b want 01", {bus_if.busy, bus_if.lose});
            miscompares++;
        end
        start_game();
        step_clk(16);
        do_show(0);
        step_clk(19);
        bus_if.btn = onehot(m_seq[0]);
        step_clk(1);
        vectors++;
        if ({bus_if.busy, bus_if.lose} !== 2'b10) begin
            $display("FAIL expiry_press: got busy/lose=%b want 10", {bus_if.busy, bus_if.lose});
            miscompares++;
        end
        bus_if.btn = 3'b000;
        step_clk(2);
        vectors++;
        if ({bus_if.level, bus_if.sym_valid} !== {4'd1, 1'b1}) begin
            $display("FAIL expiry_next: got level/v=%b want 00011", {bus_if.level, bus_if.sym_valid});
            miscompares++;
        end
    endtask

    task automatic test_win();
        reset = 1'b1;
        step_clk(1);
        reset = 1'b0;
        m_lfsr = 8'hA5;
        start_game();
        step_clk(16);
        for (int lvl = 0; lvl <= 15; lvl++) begin
            do_show(lvl);
            do_press(lvl);
            step_clk(1);
            if (lvl < 15) begin
                vectors++;
                if (bus_if.level !== 4'(lvl + 1)) begin
                    $display("FAIL win_level: got level=%0d want %0d", bus_if.level, lvl + 1);
                    miscompares++;
                end
            end
        end
        vectors++;
        if ({bus_if.win, bus_if.lose, bus_if.busy, bus_if.level, bus_if.step} !== {3'b100, 4'd15, 4'd15}) begin
            $display("FAIL win_pulse: got win/lose/busy/level/step=%b want 10011111111",
                     {bus_if.win, bus_if.lose, bus_if.busy, bus_if.level, bus_if.step});
            miscompares++;
        end
        step_clk(1);
        vectors++;
        if ({bus_if.win, bus_if.busy, bus_if.level} !== {2'b00, 4'd15}) begin
            $display("FAIL win_hold: got win/busy/level=%b want 001111", {bus_if.win, bus_if.busy, bus_if.level});
            miscompares++;
        end
        // Second game continues the LFSR rather than restarting from the seed.
        start_game();
        step_clk(16);
        for (int lvl = 0; lvl <= 3; lvl++) begin
            do_show(lvl);
            do_press(lvl);
            step_clk(1);
        end
    endtask

    task automatic test_reset_mid();
        step_clk(3);
        reset = 1'b1;
        step_clk(1);
        vectors++;
        if (outs !== 14'd0) begin
            $display("FAIL reset_show_on: got %b want 0", outs);
            miscompares++;
        end
        reset = 1'b0;
        m_lfsr = 8'hA5;
        start_game();
        step_clk(5);
        bus_if.start = 1'b1;
        step_clk(1);
        bus_if.start = 1'b0;
        step_clk(10);
        vectors++;
        if ({bus_if.sym_valid, bus_if.sym} !== {1'b1, m_seq[0]}) begin
            $display("FAIL start_busy_ignored: got v/sym=%b want %b", {bus_if.sym_valid, bus_if.sym}, {1'b1, m_seq[0]});
            miscompares++;
        end
        do_show(0);
        bus_if.btn = onehot(m_seq[0]);
        step_clk(4);
        vectors++;
        if ({bus_if.busy, bus_if.lose, bus_if.win, bus_if.level} !== {3'b100, 4'd0}) begin
            $display("FAIL held_btn: got busy/lose/win/level=%b want 1000000",
                     {bus_if.busy, bus_if.lose, bus_if.win, bus_if.level});
            miscompares++;
        end
        reset = 1'b1;
        step_clk(1);
        vectors++;
        if (outs !== 14'd0) begin
            $display("FAIL reset_wait_rel: got %b want 0", outs);
            miscompares++;
        end
        reset = 1'b0;
        bus_if.btn = 3'b000;
        step_clk(1);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.start = 1'b0;
        bus_if.btn = 3'b000;
        test_reset();
        test_start();
        test_level_up();
        test_wrong_button();
        test_multi_bit();
        test_timeout();
        test_win();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
